// File: rtl/reg_load_arbiter_if.sv
// reg_load_arbiter_if: request/data/ack bundle between requesters and the shared-register arbiter
interface reg_load_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       reg_d;
  logic                   reg_ce;
  logic [IW-1:0]          grant_id;
  logic                   busy;
  modport master (output req, data, input ack, reg_d, reg_ce, grant_id, busy);
  modport slave  (input req, data, output ack, reg_d, reg_ce, grant_id, busy);
endinterface

// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter: round-robin arbiter loading one shared CE register, then a four-phase REQ/ACK with the winner
module reg_load_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int HOLD  = 2
) (
  input logic              i_clk,
  input logic              i_rst_n,
  reg_load_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(HOLD + 1) + 1;
  typedef enum logic [1:0] {IDLE, LOAD, ACKW, COOL} state_t;
  state_t           r_state, w_next;
  logic [IW-1:0]    r_last, r_gid, w_win, w_idx;
  logic             w_found;
  logic [WIDTH-1:0] r_d;
  logic             r_ce, r_busy;
  logic [N_REQ-1:0] r_ack;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_data [N_REQ];
  genvar g;
  for (g = 0; g < N_REQ; g++) begin : g_data
    assign w_data[g] = bus.data[g*WIDTH +: WIDTH];
  end
  // Scan farthest-to-nearest from LAST so the nearest set request after LAST is the final pick
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_last) + k) % N_REQ);
      if (bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end
  // Next-state logic; only the granted requester's REQ matters once busy
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_found ? LOAD : IDLE;
      LOAD:    w_next = ACKW;
      ACKW:    w_next = bus.req[r_gid] ? ACKW : ((HOLD > 0) ? COOL : IDLE);
      COOL:    w_next = (r_cnt == '0) ? IDLE : COOL;
      default: w_next = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  // Registered outputs, grant capture and cooldown counter (preloaded outside COOL)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= IW'(N_REQ - 1);
      r_gid  <= '0;
      r_d    <= '0;
      r_ce   <= 1'b0;
      r_busy <= 1'b0;
      r_ack  <= '0;
      r_cnt  <= '0;
    end else begin
      r_ce   <= (w_next == LOAD);
      r_busy <= (w_next != IDLE);
      r_ack  <= (w_next == ACKW) ? (N_REQ'(1) << r_gid) : '0;
      r_cnt  <= (r_state != COOL) ? CW'((HOLD > 0) ? HOLD - 1 : 0) : r_cnt - CW'(1);
      if (r_state == IDLE && w_found) begin
        r_d    <= w_data[w_win];
        r_gid  <= w_win;
        r_last <= w_win;
      end
    end
  end
  assign bus.ack      = r_ack;
  assign bus.reg_d    = r_d;
  assign bus.reg_ce   = r_ce;
  assign bus.grant_id = r_gid;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_reg_load_arbiter.sv
// tb_reg_load_arbiter: scoreboard bench for the round-robin register-load arbiter (HOLD=2 and HOLD=0 builds)
module tb_reg_load_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  reg_load_arbiter_if #(.N_REQ(4), .WIDTH(4)) ifa ();
  reg_load_arbiter_if #(.N_REQ(4), .WIDTH(4)) ifb ();
  reg_load_arbiter #(.N_REQ(4), .WIDTH(4), .HOLD(2)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
  reg_load_arbiter #(.N_REQ(4), .WIDTH(4), .HOLD(0)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));
  typedef struct {int id; int d; int gap;} exp_t;
  exp_t exp_q[$];
  logic [3:0] q_model = '0;
  logic prev_ce = 1'b0;
  logic ack_due = 1'b0;
  int id_due = 0;
  int d_due = 0;
  int last_ce = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int id, input int d, input int gap);
    exp_q.push_back('{id, d, gap});
  endtask
  task automatic set_d(input int i, input int v);
    ifa.data[i*4 +: 4] = 4'(v);
  endtask
  task automatic wait_idle();
    for (int k = 0; k < 50 && ifa.busy; k++) tick();
    chk("idle", int'(ifa.busy), 0);
  endtask
  task automatic txn(input logic [3:0] mask, input int chg_id = -1, input int chg_d = 0);
    ifa.req = mask;
    tick();
    if (chg_id >= 0) set_d(chg_id, chg_d);
    for (int k = 0; k < 100 && (ifa.req != 0 || ifa.busy); k++) begin
      ifa.req = ifa.req & ~ifa.ack;
      tick();
    end
    chk("txn_done", int'({ifa.req, ifa.busy}), 0);
  endtask
  // Shared register model and cycle count
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifa.reg_ce) q_model <= ifa.reg_d;
  end
  // Monitor: each CE pulse pops the scoreboard; the following cycle must show the matching ACK and Q
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ack_due <= 1'b0;
      prev_ce <= 1'b0;
    end else begin
      if (ack_due) begin
        chk("ack", int'(ifa.ack), 1 << id_due);
        chk("q_at_ack", int'(q_model), d_due);
      end
      ack_due <= 1'b0;
      if (ifa.reg_ce) begin
        chk("ce_consec", int'(prev_ce), 0);
        chk("sb_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("grant_id", int'(ifa.grant_id), e.id);
          chk("reg_d", int'(ifa.reg_d), e.d);
          if (e.gap != 0) chk("ce_gap", cyc - last_ce, e.gap);
          ack_due <= 1'b1;
          id_due  <= e.id;
          d_due   <= e.d;
        end
        last_ce <= cyc;
      end
      prev_ce <= ifa.reg_ce;
    end
  end
  initial begin
    int lat;
    int c[4];
    int t_ce[2];
    int g[2];
    int dd[2];
    int n_ce;
    int t_fall;
    int busy_fall;
    logic [3:0] prev_ack;
    ifa.req = '0;
    ifa.data = '0;
    ifb.req = '0;
    ifb.data = 16'h0021;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_ack", int'(ifa.ack), 0);
    chk("rst_ce", int'(ifa.reg_ce), 0);
    chk("rst_d", int'(ifa.reg_d), 0);
    chk("rst_gid", int'(ifa.grant_id), 0);
    chk("rst_busy", int'(ifa.busy), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    set_d(0, 'hA);
    push(0, 'hA, 0);
    ifa.req = 4'b0001;
    lat = 0;
    for (int k = 0; k < 10 && !ifa.ack[0]; k++) begin
      tick();
      lat++;
    end
    chk("ack_lat", lat, 2);
    chk("gid0", int'(ifa.grant_id), 0);
    ifa.req = '0;
    tick();
    chk("ack_drop", int'(ifa.ack), 0);
    chk("busy_cool1", int'(ifa.busy), 1);
    tick();
    chk("busy_cool2", int'(ifa.busy), 1);
    tick();
    chk("busy_idle", int'(ifa.busy), 0);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      set_d(i, i + 4);
      c[i] = 0;
    end
    push(0, 4, 0);
    push(1, 5, 6);
    push(2, 6, 6);
    push(3, 7, 6);
    push(0, 4, 6);
    push(1, 5, 6);
    ifa.req = 4'b1111;
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (ifa.ack[i]) c[i]++;
        if (c[i] == 2 && ifa.req[i]) ifa.req[i] = 1'b0;
        else if (c[i] >= 2 && !ifa.ack[i]) begin
          ifa.req[i] = 1'b1;
          c[i] = 0;
        end
      end
    end
    chk("rr_done", exp_q.size(), 0);
    ifa.req = '0;
    wait_idle();
    push(3, 7, 0);
    txn(4'b1000);
    push(0, 4, 0);
    push(3, 7, 5);
    txn(4'b1001);
    push(0, 4, 0);
    txn(4'b0001);
    push(0, 4, 0);
    txn(4'b0001);
    set_d(2, 5);
    push(2, 5, 0);
    txn(4'b0100, 2, 'hC);
    set_d(2, 3);
    push(2, 3, 0);
    ifa.req = 4'b0100;
    for (int k = 0; k < 10 && !ifa.ack[2]; k++) tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    ifa.req = '0;
    #1;
    chk("mid_rst_ack", int'(ifa.ack), 0);
    chk("mid_rst_ce", int'(ifa.reg_ce), 0);
    chk("mid_rst_busy", int'(ifa.busy), 0);
    chk("mid_rst_gid", int'(ifa.grant_id), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    set_d(1, 9);
    set_d(2, 6);
    push(1, 9, 0);
    push(2, 6, 5);
    txn(4'b0110);
    n_ce = 0;
    t_fall = -1;
    busy_fall = 1;
    prev_ack = '0;
    ifb.req = 4'b0011;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (ifb.reg_ce && n_ce < 2) begin
        t_ce[n_ce] = k;
        g[n_ce] = int'(ifb.grant_id);
        dd[n_ce] = int'(ifb.reg_d);
        n_ce++;
      end
      if (prev_ack != 0 && ifb.ack == 0 && t_fall < 0) begin
        t_fall = k;
        busy_fall = int'(ifb.busy);
      end
      prev_ack = ifb.ack;
      ifb.req = ifb.req & ~ifb.ack;
    end
    chk("h0_ce_count", n_ce, 2);
    if (n_ce == 2) begin
      chk("h0_gid0", g[0], 0);
      chk("h0_gid1", g[1], 1);
      chk("h0_d0", dd[0], 1);
      chk("h0_d1", dd[1], 2);
      chk("h0_ce_after_ackfall", t_ce[1] - t_fall, 1);
      chk("h0_ce_spacing", t_ce[1] - t_ce[0], 3);
    end
    chk("h0_busy_at_fall", busy_fall, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
